aes_subbytes_sequencer: RTL

Time-multiplexed AES SubBytes engine: one 32-bit lane of four `sbox` instances is shared between the cipher-state requester (128-bit, one column per cycle) and the key-expansion SubWord requester (32-bit, single cycle). It replaces a full 16-sbox SubBytes stage in area-constrained builds. It sits between the round controller and the key scheduler.

---
 rtl/aes_subbytes_sequencer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/aes_subbytes_sequencer.sv
// aes_subbytes_sequencer
// One 32-bit lane of four S-boxes is shared between two requesters. The
// 128-bit cipher state is substituted one column per cycle, and the 32-bit
// key-schedule SubWord is substituted in a single cycle. A word request can
// pre-empt an in-flight state column when WD_PRIO is set; the column is then
// retried on the next free cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | state buffer free, st_ready high, lane serves words only
// S_BUSY  | columns 0..3 of the buffered state pass through the lane

// aes_sbox: byte substitution computed as the GF(2^8) inverse followed by
// the AES affine transform, which avoids a 256-entry table per instance.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as x^254 = x^2 * x^4 * ... * x^128; zero maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    logic [7:0] w_inv;

    // Inverse, then affine transform with the 0x63 constant.
    always_comb begin
        w_inv  = gf_inv(i_byte);
        o_byte = w_inv
               ^ {w_inv[6:0], w_inv[7]}
               ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]}
               ^ {w_inv[3:0], w_inv[7:4]}
               ^ 8'h63;
    end

endmodule

module aes_subbytes_sequencer #(
    parameter int WD_PRIO = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_st_valid,
    output logic         o_st_ready,
    input  logic [0:127] i_st_in,
    output logic [0:127] o_st_out,
    output logic         o_st_done,
    input  logic         i_wd_valid,
    output logic         o_wd_ready,
    input  logic [0:31]  i_wd_in,
    output logic [0:31]  o_wd_out,
    output logic         o_wd_done,
    output logic         o_busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]   r_state;
    logic [1:0]   r_col;
    logic [0:127] r_st_buf;
    logic [0:127] r_res_buf;
    logic [0:127] r_st_out;
    logic [0:31]  r_wd_out;
    logic         r_st_done;
    logic         r_wd_done;

    logic         w_st_ready;
    logic         w_wd_ready;
    logic         w_st_fire;
    logic         w_wd_fire;
    logic         w_col_step;
    logic [0:31]  w_lane_in;
    logic [0:31]  w_lane_out;
    logic [0:127] w_res_next;

    // Handshake qualifiers; both readies drop while reset is asserted.
    always_comb begin
        w_st_ready = !i_rst && (r_state == S_IDLE);
        w_wd_ready = !i_rst && ((r_state == S_IDLE) || (WD_PRIO != 0));
        w_st_fire  = i_st_valid && w_st_ready;
        w_wd_fire  = i_wd_valid && w_wd_ready;
        // A word in flight owns the lane, so the state column waits a cycle.
        w_col_step = (r_state == S_BUSY) && !w_wd_fire;
    end

    // Lane input mux: the word is taken straight from the port, otherwise
    // the current column of the buffered state.
    always_comb begin
        w_lane_in = r_st_buf[{r_col, 5'd0} +: 32];
        if (w_wd_fire) begin
            w_lane_in = i_wd_in;
        end
    end

    genvar g_byte;
    generate
        for (g_byte = 0; g_byte < 4; g_byte++) begin : g_lane
            aes_sbox u_sbox (
                .i_byte (w_lane_in[g_byte*8 +: 8]),
                .o_byte (w_lane_out[g_byte*8 +: 8])
            );
        end
    endgenerate

    // Result buffer with the current column replaced by the lane output;
    // on the last column this is the complete substituted state.
    always_comb begin
        w_res_next = r_res_buf;
        w_res_next[{r_col, 5'd0} +: 32] = w_lane_out;
    end

    // Sequencer FSM, column counter and buffers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_col     <= 2'd0;
            r_st_buf  <= '0;
            r_res_buf <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_st_fire) begin
                        r_st_buf <= i_st_in;
                        r_col    <= 2'd0;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_col_step) begin
                        r_res_buf <= w_res_next;
                        r_col     <= r_col + 2'd1;
                        if (r_col == 2'd3) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // State result register and completion pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_st_out  <= '0;
            r_st_done <= 1'b0;
        end else begin
            r_st_done <= 1'b0;
            if (w_col_step && (r_col == 2'd3)) begin
                r_st_out  <= w_res_next;
                r_st_done <= 1'b1;
            end
        end
    end

    // Word result register and completion pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wd_out  <= '0;
            r_wd_done <= 1'b0;
        end else begin
            r_wd_done <= 1'b0;
            if (w_wd_fire) begin
                r_wd_out  <= w_lane_out;
                r_wd_done <= 1'b1;
            end
        end
    end

    assign o_st_ready = w_st_ready;
    assign o_wd_ready = w_wd_ready;
    assign o_st_out   = r_st_out;
    assign o_st_done  = r_st_done;
    assign o_wd_out   = r_wd_out;
    assign o_wd_done  = r_wd_done;
    assign o_busy     = (r_state == S_BUSY);

endmodule
